// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state encoding, default matrix size and index-width helper for the matmul sequencer
package matmul_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam int N_DEF = 3;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/matmul_idx_counter.sv
// matmul_idx_counter: 0..N-1 wrapping index counter; ports clock, reset, clear, en in; value out, wrap high while value is N-1
module matmul_idx_counter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [IW-1:0] value,
  output logic          wrap
);
  assign wrap = value == IW'(N - 1);
  always_ff @(posedge clock)
    if (reset || clear) value <= '0;
    else if (en) value <= wrap ? '0 : value + 1'b1;
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: C = A x B control FSM; in clock/reset/start/abort; out busy/done, A(i,k)/B(k,j) read addresses, mac_en/mac_clear, res_we with C(i,j) address
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] a_row,
  output logic [IW-1:0] a_col,
  output logic [IW-1:0] b_row,
  output logic [IW-1:0] b_col,
  output logic          mac_en,
  output logic          mac_clear,
  output logic          res_we,
  output logic [IW-1:0] res_row,
  output logic [IW-1:0] res_col
);
  state_t state, state_n;
  logic [IW-1:0] i, j, k;
  logic i_w, j_w, k_w, clr;
  // Counters are zeroed whenever the FSM heads to IDLE, so IDLE always shows zero addresses.
  assign clr = state_n == IDLE;
  matmul_idx_counter #(.N(N), .IW(IW)) u_k (
    .clock(clock), .reset(reset), .clear(clr), .en(state == ISSUE), .value(k), .wrap(k_w)
  );
  matmul_idx_counter #(.N(N), .IW(IW)) u_j (
    .clock(clock), .reset(reset), .clear(clr), .en(state == WRITE), .value(j), .wrap(j_w)
  );
  matmul_idx_counter #(.N(N), .IW(IW)) u_i (
    .clock(clock), .reset(reset), .clear(clr), .en(state == WRITE && j_w), .value(i), .wrap(i_w)
  );
  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = start ? ISSUE : IDLE;
        ISSUE:   state_n = k_w ? DRAIN : ISSUE;
        DRAIN:   state_n = WRITE;
        WRITE:   state_n = (i_w && j_w) ? DONE : ISSUE;
        default: state_n = IDLE;
      endcase
  end
  // mac strobes trail the issue cycle by the one-cycle read latency; abort kills the pending one.
  always_ff @(posedge clock)
    if (reset) begin
      state     <= IDLE;
      mac_en    <= 1'b0;
      mac_clear <= 1'b0;
    end else begin
      state     <= state_n;
      mac_en    <= state == ISSUE && !abort;
      mac_clear <= state == ISSUE && !abort && k == '0;
    end
  assign busy    = state == ISSUE || state == DRAIN || state == WRITE;
  assign done    = state == DONE;
  assign res_we  = state == WRITE;
  assign a_row   = i;
  assign a_col   = k;
  assign b_row   = k;
  assign b_col   = j;
  assign res_row = i;
  assign res_col = j;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: randomized self-checking bench with cycle-timing and MAC data reference models
module tb_matmul_sequencer;
  localparam int N = 3;
  localparam int IW = 2;
  localparam int TRUN = N * N * (N + 2);
  localparam int TDONE = TRUN + 1;
  logic clock = 1'b0;
  logic reset, start, abort;
  logic busy, done, mac_en, mac_clear, res_we;
  logic [IW-1:0] a_row, a_col, b_row, b_col, res_row, res_col;
  int total = 0, bad = 0;
  int A[N][N], B[N][N], C[N][N];
  int a_q = 0, b_q = 0, acc = 0;
  bit active = 0;
  int t = 0;
  int wr_cnt, done_cnt, first_we, last_we, done_t;
  always #5 clock = ~clock;
  matmul_sequencer #(.N(N), .IW(IW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
    .mac_en(mac_en), .mac_clear(mac_clear),
    .res_we(res_we), .res_row(res_row), .res_col(res_col)
  );
  always @(posedge clock) begin
    if (res_we) begin
      C[res_row][res_col] = acc;
      wr_cnt++;
      if (first_we < 0) first_we = t;
      last_we = t;
    end
    if (done) begin
      done_cnt++;
      done_t = t;
    end
    if (mac_en) acc = mac_clear ? a_q * b_q : acc + a_q * b_q;
    a_q = A[a_row][a_col];
    b_q = B[b_row][b_col];
    if (reset) active = 0;
    else if (active) begin
      if (abort || t == TDONE) active = 0;
      else t++;
    end else if (start && !abort) begin
      active = 1;
      t = 1;
    end
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0d)", tag, got, exp, t);
    end
  endtask
  task automatic check_outputs();
    bit run, iss, wr, me, mc, dn;
    int e, p;
    run = active && t <= TRUN;
    dn  = active && t == TDONE;
    e   = run ? (t - 1) / (N + 2) : 0;
    p   = run ? (t - 1) % (N + 2) : 0;
    iss = run && p < N;
    wr  = run && p == N + 1;
    me  = run && p >= 1 && p <= N;
    mc  = run && p == 1;
    chk("busy", busy, run);
    chk("done", done, dn);
    chk("mac_en", mac_en, me);
    chk("mac_clear", mac_clear, mc);
    chk("res_we", res_we, wr);
    if (!active) begin
      chk("idle_a_row", a_row, 0);
      chk("idle_a_col", a_col, 0);
      chk("idle_b_row", b_row, 0);
      chk("idle_b_col", b_col, 0);
      chk("idle_res_row", res_row, 0);
      chk("idle_res_col", res_col, 0);
    end
    if (iss) begin
      chk("a_row", a_row, e / N);
      chk("a_col", a_col, p);
      chk("b_row", b_row, p);
      chk("b_col", b_col, e % N);
    end
    if (wr) begin
      chk("res_row", res_row, e / N);
      chk("res_col", res_col, e % N);
    end
  endtask
  task automatic step();
    @(negedge clock);
    check_outputs();
  endtask
  task automatic clear_stats();
    wr_cnt = 0;
    done_cnt = 0;
    first_we = -1;
    last_we = -1;
    done_t = -1;
  endtask
  task automatic load_mats(input bit ident);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r][c] = ident ? int'(r == c) : int'($urandom_range(0, 15));
        B[r][c] = ident ? r * N + c + 1 : int'($urandom_range(0, 15));
        C[r][c] = -1;
      end
  endtask
  task automatic check_c(input string tag);
    int s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int q = 0; q < N; q++) s += A[r][q] * B[q][c];
        chk($sformatf("%s_c%0d%0d", tag, r, c), C[r][c], s);
      end
  endtask
  task automatic run_out(input string tag);
    for (int n = 0; n < 200 && active; n++) step();
    chk({tag, "_timeout"}, active, 0);
  endtask
  task automatic run_to(input int tt);
    for (int n = 0; n < 200 && active && t < tt; n++) step();
    chk("reach_cycle", t, tt);
  endtask
  initial begin
    int ab;
    reset = 1;
    start = 0;
    abort = 0;
    clear_stats();
    step();
    step();
    reset = 0;
    step();
    load_mats(1);
    clear_stats();
    start = 1;
    step();
    start = 0;
    run_out("ident");
    chk("ident_first_we", first_we, N + 2);
    chk("ident_last_we", last_we, TRUN);
    chk("ident_done_t", done_t, TDONE);
    chk("ident_done_cnt", done_cnt, 1);
    chk("ident_wr_cnt", wr_cnt, N * N);
    check_c("ident");
    load_mats(0);
    clear_stats();
    start = 1;
    step();
    run_out("held");
    start = 0;
    step();
    step();
    chk("held_done_cnt", done_cnt, 1);
    chk("held_wr_cnt", wr_cnt, N * N);
    check_c("held");
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    step();
    chk("sa_idle_wr", wr_cnt, N * N);
    load_mats(0);
    clear_stats();
    start = 1;
    step();
    start = 0;
    run_to(12);
    abort = 1;
    step();
    abort = 0;
    for (int n = 0; n < 60; n++) step();
    chk("abort12_wr_cnt", wr_cnt, 2);
    chk("abort12_done_cnt", done_cnt, 0);
    for (int r = 0; r < 4; r++) begin
      ab = $urandom_range(1, TRUN);
      load_mats(0);
      clear_stats();
      start = 1;
      step();
      start = 0;
      run_to(ab);
      abort = 1;
      step();
      abort = 0;
      for (int n = 0; n < 8; n++) step();
      chk("rabort_wr_cnt", wr_cnt, ab / (N + 2));
      chk("rabort_done_cnt", done_cnt, 0);
    end
    load_mats(0);
    clear_stats();
    start = 1;
    step();
    run_to(20);
    reset = 1;
    step();
    reset = 0;
    chk("rst20_wr_cnt", wr_cnt, 4);
    chk("rst20_done_cnt", done_cnt, 0);
    clear_stats();
    step();
    start = 0;
    run_out("restart");
    chk("restart_first_we", first_we, N + 2);
    chk("restart_wr_cnt", wr_cnt, N * N);
    chk("restart_done_cnt", done_cnt, 1);
    check_c("restart");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
